// File: rtl/color_tracker_multi.sv
// Multi-channel RGB565 colour-blob tracker: per-channel range match, bounding-box
// accumulation, deadbanded aim point, multi-frame confirmation and lost-target timer.
module color_tracker_multi #(
  parameter int NUM_CH         = 2,
  parameter int H_ACTIVE       = 640,
  parameter int X_MARGIN       = 10,
  parameter int MIN_PIXELS     = 50,
  parameter int DEADBAND       = 10,
  parameter int CONFIRM_FRAMES = 2,
  parameter int LOST_CYCLES    = 75_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v_sync,
  input  logic                  DE,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic [15:0]           data,
  input  logic [5*NUM_CH-1:0]   cfg_r_lo,
  input  logic [5*NUM_CH-1:0]   cfg_r_hi,
  input  logic [6*NUM_CH-1:0]   cfg_g_lo,
  input  logic [6*NUM_CH-1:0]   cfg_g_hi,
  input  logic [5*NUM_CH-1:0]   cfg_b_lo,
  input  logic [5*NUM_CH-1:0]   cfg_b_hi,
  output logic [10*NUM_CH-1:0]  aim_x,
  output logic [10*NUM_CH-1:0]  aim_y,
  output logic [NUM_CH-1:0]     aim_detected,
  output logic [10*NUM_CH-1:0]  x_min_out,
  output logic [10*NUM_CH-1:0]  x_max_out,
  output logic [10*NUM_CH-1:0]  y_min_out,
  output logic [10*NUM_CH-1:0]  y_max_out,
  output logic [17*NUM_CH-1:0]  pixel_count_out,
  output logic [NUM_CH-1:0]     target_off,
  output logic                  frame_valid
);

  localparam int SW = (CONFIRM_FRAMES < 2) ? 1 : $clog2(CONFIRM_FRAMES + 1);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam logic [9:0]    X_LO  = 10'(X_MARGIN);
  localparam logic [9:0]    X_HI  = 10'(H_ACTIVE - X_MARGIN);
  localparam logic [16:0]   MIN_P = 17'(MIN_PIXELS);
  localparam logic [9:0]    DBAND = 10'(DEADBAND);
  localparam logic [SW-1:0] CONF  = SW'(CONFIRM_FRAMES);
  localparam logic [LW-1:0] LOST  = LW'(LOST_CYCLES);

  logic       vsync_d_q;
  logic       frame_valid_q;
  logic       vsync_start;
  logic       in_window;
  logic [4:0] pix_r;
  logic [5:0] pix_g;
  logic [4:0] pix_b;

  assign vsync_start = v_sync && !vsync_d_q;
  assign in_window   = (x_pixel > X_LO) && (x_pixel < X_HI);
  assign pix_r       = data[15:11];
  assign pix_g       = data[10:5];
  assign pix_b       = data[4:0];
  assign frame_valid = frame_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      vsync_d_q     <= v_sync;
      frame_valid_q <= vsync_start;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic          match, acc, hit;
    logic [9:0]    xmin_q, xmax_q, ymin_q, ymax_q;
    logic [16:0]   cnt_q, pcnt_q;
    logic [9:0]    aimx_q, aimy_q, bx0_q, bx1_q, by0_q, by1_q;
    logic          det_q, off_q;
    logic [SW-1:0] streak_q, streak_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [10:0]   sum_x, sum_y;
    logic [9:0]    cx, cy, dx, dy;

    assign match = (pix_r >= cfg_r_lo[5*k +: 5]) && (pix_r <= cfg_r_hi[5*k +: 5]) &&
                   (pix_g >= cfg_g_lo[6*k +: 6]) && (pix_g <= cfg_g_hi[6*k +: 6]) &&
                   (pix_b >= cfg_b_lo[5*k +: 5]) && (pix_b <= cfg_b_hi[5*k +: 5]);
    assign acc   = DE && match && in_window && !vsync_start;

    assign sum_x    = {1'b0, xmin_q} + {1'b0, xmax_q};
    assign sum_y    = {1'b0, ymin_q} + {1'b0, ymax_q};
    assign cx       = sum_x[10:1];
    assign cy       = sum_y[10:1];
    assign dx       = (cx >= aimx_q) ? cx - aimx_q : aimx_q - cx;
    assign dy       = (cy >= aimy_q) ? cy - aimy_q : aimy_q - cy;
    assign hit      = cnt_q > MIN_P;
    assign streak_d = (streak_q == CONF) ? CONF : streak_q + 1'b1;
    assign lost_d   = (lost_q == LOST) ? LOST : lost_q + 1'b1;

    // Accumulators restart from the empty box on every frame close.
    always_ff @(posedge clk or posedge reset) begin
      if (reset || vsync_start) begin
        xmin_q <= 10'd1023;
        ymin_q <= 10'd1023;
        xmax_q <= 10'd0;
        ymax_q <= 10'd0;
        cnt_q  <= 17'd0;
      end else if (acc) begin
        if (x_pixel < xmin_q) xmin_q <= x_pixel;
        if (x_pixel > xmax_q) xmax_q <= x_pixel;
        if (y_pixel < ymin_q) ymin_q <= y_pixel;
        if (y_pixel > ymax_q) ymax_q <= y_pixel;
        if (cnt_q != '1) cnt_q <= cnt_q + 17'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        aimx_q   <= '0;
        aimy_q   <= '0;
        bx0_q    <= '0;
        bx1_q    <= '0;
        by0_q    <= '0;
        by1_q    <= '0;
        pcnt_q   <= '0;
        det_q    <= 1'b0;
        streak_q <= '0;
      end else if (vsync_start) begin
        pcnt_q <= cnt_q;
        if (hit) begin
          // Unconfirmed targets snap; confirmed ones move only past the deadband.
          if (!det_q || dx > DBAND) aimx_q <= cx;
          if (!det_q || dy > DBAND) aimy_q <= cy;
          bx0_q    <= xmin_q;
          bx1_q    <= xmax_q;
          by0_q    <= ymin_q;
          by1_q    <= ymax_q;
          streak_q <= streak_d;
          det_q    <= (streak_d == CONF);
        end else begin
          streak_q <= '0;
          det_q    <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lost_q <= '0;
        off_q  <= 1'b0;
      end else if (det_q) begin
        lost_q <= '0;
        off_q  <= 1'b0;
      end else begin
        lost_q <= lost_d;
        off_q  <= (lost_d == LOST);
      end
    end

    assign aim_x[10*k +: 10]           = aimx_q;
    assign aim_y[10*k +: 10]           = aimy_q;
    assign aim_detected[k]             = det_q;
    assign x_min_out[10*k +: 10]       = bx0_q;
    assign x_max_out[10*k +: 10]       = bx1_q;
    assign y_min_out[10*k +: 10]       = by0_q;
    assign y_max_out[10*k +: 10]       = by1_q;
    assign pixel_count_out[17*k +: 17] = pcnt_q;
    assign target_off[k]               = off_q;
  end

endmodule

// File: tb/tb_color_tracker_multi.sv
// Directed bench for color_tracker_multi: two channels, LOST_CYCLES=100,
// hand-computed frame results for acquisition, deadband, threshold, margins and reset.
module tb_color_tracker_multi;

  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v_sync = 1'b0;
  logic DE = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic [15:0] data = '0;
  logic [5*NCH-1:0] cfg_r_lo, cfg_r_hi, cfg_b_lo, cfg_b_hi;
  logic [6*NCH-1:0] cfg_g_lo, cfg_g_hi;
  logic [10*NCH-1:0] aim_x, aim_y, x_min_out, x_max_out, y_min_out, y_max_out;
  logic [17*NCH-1:0] pixel_count_out;
  logic [NCH-1:0]    aim_detected, target_off;
  logic              frame_valid;

  // ch0: R 21..31, G 0..14, B 0..14.  ch1: R 28..31, any G/B.
  assign cfg_r_lo = {5'd28, 5'd21};
  assign cfg_r_hi = {5'd31, 5'd31};
  assign cfg_g_lo = {6'd0, 6'd0};
  assign cfg_g_hi = {6'd63, 6'd14};
  assign cfg_b_lo = {5'd0, 5'd0};
  assign cfg_b_hi = {5'd31, 5'd14};

  localparam logic [15:0] C_RED0 = 16'hB000;  // R=22: ch0 only
  localparam logic [15:0] C_RED  = 16'hF800;  // R=31: ch0 and ch1
  localparam logic [15:0] C_GRN  = 16'h07E0;  // matches neither

  color_tracker_multi #(
    .NUM_CH(NCH), .H_ACTIVE(640), .X_MARGIN(10), .MIN_PIXELS(50),
    .DEADBAND(10), .CONFIRM_FRAMES(2), .LOST_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .data(data),
    .cfg_r_lo(cfg_r_lo), .cfg_r_hi(cfg_r_hi),
    .cfg_g_lo(cfg_g_lo), .cfg_g_hi(cfg_g_hi),
    .cfg_b_lo(cfg_b_lo), .cfg_b_hi(cfg_b_hi),
    .aim_x(aim_x), .aim_y(aim_y), .aim_detected(aim_detected),
    .x_min_out(x_min_out), .x_max_out(x_max_out),
    .y_min_out(y_min_out), .y_max_out(y_max_out),
    .pixel_count_out(pixel_count_out), .target_off(target_off),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ch(input string tag, input int k, input int e_cnt,
                          input int e_det, input int e_ax, input int e_ay);
    check({tag, ".cnt"},   32'(pixel_count_out[17*k +: 17]), 32'(e_cnt));
    check({tag, ".det"},   32'(aim_detected[k]),             32'(e_det));
    check({tag, ".aim_x"}, 32'(aim_x[10*k +: 10]),           32'(e_ax));
    check({tag, ".aim_y"}, 32'(aim_y[10*k +: 10]),           32'(e_ay));
  endtask

  task automatic check_bb(input string tag, input int k, input int x0, input int x1,
                          input int y0, input int y1);
    check({tag, ".xmin"}, 32'(x_min_out[10*k +: 10]), 32'(x0));
    check({tag, ".xmax"}, 32'(x_max_out[10*k +: 10]), 32'(x1));
    check({tag, ".ymin"}, 32'(y_min_out[10*k +: 10]), 32'(y0));
    check({tag, ".ymax"}, 32'(y_max_out[10*k +: 10]), 32'(y1));
  endtask

  task automatic draw(input int x0, input int x1, input int y0, input int y1,
                      input logic [15:0] c);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        @(negedge clk);
        DE = 1'b1; x_pixel = 10'(x); y_pixel = 10'(y); data = c;
      end
    end
    @(negedge clk);
    DE = 1'b0;
  endtask

  // Closes a frame with a matching pixel presented on the sync cycle (must be
  // dropped), then holds v_sync high to confirm no second close.
  task automatic close_frame();
    int extra;
    @(negedge clk);
    v_sync = 1'b1; DE = 1'b1; data = C_RED; x_pixel = 10'd400; y_pixel = 10'd300;
    @(posedge clk); #1;
    check("fv_pulse", 32'(frame_valid), 32'd1);
    @(negedge clk);
    DE = 1'b0;
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (frame_valid) extra++;
    end
    check("fv_once", 32'(extra), 32'd0);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_ch("rst0", 0, 0, 0, 0, 0);
    check_bb("rst0", 0, 0, 0, 0, 0);
    check("rst_fv",  32'(frame_valid), 32'd0);
    check("rst_off", 32'(target_off),  32'd0);

    @(negedge clk);
    reset = 1'b0;
    repeat (99) @(posedge clk);
    #1 check("off_99", 32'(target_off), 32'd0);
    @(posedge clk);
    #1 check("off_100", 32'(target_off), 32'd3);

    draw(100, 199, 50, 89, C_RED0);
    close_frame();
    check_ch("f1", 0, 4000, 0, 149, 69);
    check("f1.off0", 32'(target_off[0]), 32'd1);
    check("f1.cnt1", 32'(pixel_count_out[33:17]), 32'd0);

    draw(100, 199, 50, 89, C_RED0);
    close_frame();
    check_ch("f2", 0, 4000, 1, 149, 69);
    check_bb("f2", 0, 100, 199, 50, 89);
    check("f2.off", 32'(target_off), 32'd2);

    draw(108, 207, 50, 50, C_RED0);
    draw(108, 207, 89, 89, C_RED0);
    close_frame();
    check_ch("db8", 0, 200, 1, 149, 69);

    draw(112, 211, 50, 50, C_RED0);
    draw(112, 211, 89, 89, C_RED0);
    close_frame();
    check_ch("db12", 0, 200, 1, 161, 69);
    check_bb("db12", 0, 112, 211, 50, 89);

    draw(200, 249, 100, 100, C_RED0);
    draw(300, 319, 100, 100, C_GRN);
    close_frame();
    check_ch("th50", 0, 50, 0, 161, 69);
    check_bb("th50", 0, 112, 211, 50, 89);

    draw(200, 250, 100, 100, C_RED0);
    close_frame();
    check_ch("th51a", 0, 51, 0, 225, 100);
    draw(200, 250, 100, 100, C_RED0);
    close_frame();
    check_ch("th51b", 0, 51, 1, 225, 100);

    draw(10, 11, 5, 5, C_RED);
    draw(629, 630, 5, 5, C_RED);
    draw(300, 359, 200, 200, C_RED);
    close_frame();
    check_ch("mg0", 0, 62, 1, 320, 100);
    check_bb("mg0", 0, 11, 629, 5, 200);
    check_ch("mg1", 1, 62, 0, 320, 102);
    check_bb("mg1", 1, 11, 629, 5, 200);

    draw(300, 349, 300, 309, C_RED0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_ch("mrst", 0, 0, 0, 0, 0);
    check_bb("mrst", 0, 0, 0, 0, 0);
    check("mrst_off", 32'(target_off), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    draw(50, 99, 20, 29, C_RED0);
    close_frame();
    check_ch("post", 0, 500, 0, 74, 24);
    check_bb("post", 0, 50, 99, 20, 29);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
